// File: rtl/bitty_pkg.sv
// Shared types and constants for the bitty control sequencer: state encoding,
// instruction field positions, format codes and operand-mux select values.
package bitty_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD_S = 2'b01,
        EXEC   = 2'b10,
        WRITE  = 2'b11
    } state_e;

    localparam int INSTR_W   = 16;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int OP_W      = 3;
    localparam int FMT_W     = 2;

    // Instruction field positions (LSB of each field); imm8 overlaps Ry.
    localparam int RX_LSB  = 13;
    localparam int RY_LSB  = 10;
    localparam int IMM_LSB = 5;
    localparam int OP_LSB  = 2;
    localparam int FMT_LSB = 0;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;

    localparam logic [3:0] SEL_IMM = 4'b1000;
    localparam logic [3:0] SEL_DEF = 4'b1001;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/bitty_instr_decode.sv
// Combinational field decode of a latched bitty instruction word.
module bitty_instr_decode
    import bitty_pkg::*;
#(
    parameter int IMM_W = 8
) (
    input  logic [INSTR_W-1:0]   instr,
    output logic [REG_IDX_W-1:0] rx,
    output logic [REG_IDX_W-1:0] ry,
    output logic [IMM_W-1:0]     imm,
    output logic [OP_W-1:0]      alu_op,
    output logic                 is_imm,
    output logic                 is_illegal
);

    logic [FMT_W-1:0] fmt_s;

    assign rx     = instr[RX_LSB +: REG_IDX_W];
    assign ry     = instr[RY_LSB +: REG_IDX_W];
    assign imm    = instr[IMM_LSB +: IMM_W];
    assign alu_op = instr[OP_LSB +: OP_W];
    assign fmt_s  = instr[FMT_LSB +: FMT_W];

    assign is_imm     = (fmt_s == FMT_I);
    assign is_illegal = (fmt_s != FMT_R) && (fmt_s != FMT_I);

endmodule

// File: rtl/bitty_ctrl_fsm.sv
// Four-phase control sequencer (IDLE/LOAD_S/EXEC/WRITE) driving the operand mux,
// register enables and ALU select of the bitty datapath.
module bitty_ctrl_fsm
    import bitty_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                hold,
    output logic [3:0]          mux_sel,
    output logic [DATA_W-1:0]   im_d,
    output logic                en_s,
    output logic                en_c,
    output logic [7:0]          en_rx,
    output logic [2:0]          alu_sel,
    output logic                done,
    output logic                illegal,
    output logic [DATA_W-1:0]   retired_cnt
);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [INSTR_W-1:0]     instr_r;
    logic [DATA_W-1:0]      cnt_r;

    logic [REG_IDX_W-1:0]   rx_s;
    logic [REG_IDX_W-1:0]   ry_s;
    logic [IMM_W-1:0]       imm_s;
    logic [OP_W-1:0]        alu_op_s;
    logic                   is_imm_s;
    logic                   is_illegal_s;

    logic                   accept_s;
    logic                   active_s;
    logic                   retire_s;

    bitty_instr_decode #(
        .IMM_W      (IMM_W)
    ) u_decode (
        .instr      (instr_r),
        .rx         (rx_s),
        .ry         (ry_s),
        .imm        (imm_s),
        .alu_op     (alu_op_s),
        .is_imm     (is_imm_s),
        .is_illegal (is_illegal_s)
    );

    assign instr_ready = (state_r == IDLE) && !hold;
    assign accept_s    = instr_valid && instr_ready;
    // Enables fire only for legal formats and never while stalled.
    assign active_s    = !hold && !is_illegal_s;
    assign retire_s    = (state_r == WRITE) && !hold;

    assign im_d        = DATA_W'(imm_s);
    assign retired_cnt = cnt_r;

    // State register and instruction latch; the latch only opens on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            instr_r <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                instr_r <= instr;
            end else begin
                instr_r <= instr_r;
            end
        end
    end

    // Retired-instruction counter, wraps naturally at its full width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {DATA_W{1'b0}};
        end else if (retire_s) begin
            cnt_r <= cnt_r + {{(DATA_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next-state logic; hold freezes the sequence in place.
    always_comb begin
        state_nxt_s = state_r;
        if (hold) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        state_nxt_s = LOAD_S;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                LOAD_S:  state_nxt_s = EXEC;
                EXEC:    state_nxt_s = WRITE;
                WRITE:   state_nxt_s = IDLE;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Output decode from the current phase and the latched instruction.
    always_comb begin
        mux_sel = SEL_DEF;
        en_s    = 1'b0;
        en_c    = 1'b0;
        en_rx   = 8'h00;
        alu_sel = 3'b000;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_r)
            IDLE: begin
                mux_sel = SEL_DEF;
            end
            LOAD_S: begin
                mux_sel = {1'b0, rx_s};
                en_s    = active_s;
            end
            EXEC: begin
                mux_sel = is_imm_s ? SEL_IMM : {1'b0, ry_s};
                en_c    = active_s;
                alu_sel = alu_op_s;
            end
            WRITE: begin
                mux_sel = SEL_DEF;
                en_rx   = active_s ? reg_onehot(rx_s) : 8'h00;
                done    = !hold;
                illegal = is_illegal_s && !hold;
            end
            default: begin
                mux_sel = SEL_DEF;
            end
        endcase
    end

endmodule

// File: tb/tb_bitty_ctrl_fsm.sv
// Scoreboard bench for bitty_ctrl_fsm: a driver queues accepted instructions and
// a negedge monitor predicts every output cycle from a phase-count model.
module tb_bitty_ctrl_fsm;

    logic        clk;
    logic        reset_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        hold;

    logic        instr_ready,  instr_ready8;
    logic [3:0]  mux_sel,      mux_sel8;
    logic [15:0] im_d;
    logic [7:0]  im_d8;
    logic        en_s,         en_s8;
    logic        en_c,         en_c8;
    logic [7:0]  en_rx,        en_rx8;
    logic [2:0]  alu_sel,      alu_sel8;
    logic        done,         done8;
    logic        illegal,      illegal8;
    logic [15:0] retired_cnt;
    logic [7:0]  retired_cnt8;

    bitty_ctrl_fsm #(.DATA_W(16), .IMM_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .hold(hold), .mux_sel(mux_sel), .im_d(im_d),
        .en_s(en_s), .en_c(en_c), .en_rx(en_rx), .alu_sel(alu_sel), .done(done),
        .illegal(illegal), .retired_cnt(retired_cnt)
    );

    // Narrow-counter instance: lets the counter wrap within a short run.
    bitty_ctrl_fsm #(.DATA_W(8), .IMM_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready8), .hold(hold), .mux_sel(mux_sel8), .im_d(im_d8),
        .en_s(en_s8), .en_c(en_c8), .en_rx(en_rx8), .alu_sel(alu_sel8), .done(done8),
        .illegal(illegal8), .retired_cnt(retired_cnt8)
    );

    typedef struct {
        logic [15:0] w;
        int          acc;
    } item_t;

    item_t       q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          holds = 0;
    logic [15:0] cnt_model = 16'h0000;
    logic [15:0] last_imm = 16'h0000;
    bit          rand_hold = 1'b0;
    logic        force_hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        hold = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hold = rand_hold ? ($urandom_range(5) == 0) : force_hold;
        end
    end

    // Present one instruction until accepted, then queue it for the monitor.
    task automatic send(input logic [15:0] w);
        int t;
        instr       = w;
        instr_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(instr_ready && reset_n) && t < 64);
        n_chk++;
        if (!instr_ready) begin
            n_err++;
            $display("FAIL accept_timeout instr=%h got ready=%b want ready=1", w, instr_ready);
        end else begin
            q.push_back('{w, cyc});
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: predict every output from the instruction in flight and its phase.
    initial begin : mon
        logic [3:0]  m;
        logic        es, ec, dn, il, rd, legal;
        logic [7:0]  erx;
        logic [2:0]  as;
        logic [15:0] w, imm;
        int          p;
        bit          fl;
        forever begin
            @(negedge clk);
            m = 4'd9; es = 1'b0; ec = 1'b0; erx = 8'h00; as = 3'd0;
            dn = 1'b0; il = 1'b0; rd = 1'b1; p = 0;
            if (!reset_n) begin
                q.delete();
                holds     = 0;
                cnt_model = 16'h0000;
                last_imm  = 16'h0000;
            end
            fl  = (q.size() > 0) && (cyc > q[0].acc);
            imm = last_imm;
            if (fl) begin
                w     = q[0].w;
                legal = (w[1:0] == 2'b00) || (w[1:0] == 2'b01);
                p     = cyc - q[0].acc - holds;
                imm   = {8'h00, w[12:5]};
                rd    = 1'b0;
                if (p == 1) begin
                    m  = {1'b0, w[15:13]};
                    es = legal;
                end else if (p == 2) begin
                    m  = (w[1:0] == 2'b01) ? 4'd8 : {1'b0, w[12:10]};
                    ec = legal;
                    as = w[4:2];
                end else begin
                    erx = legal ? (8'd1 << w[15:13]) : 8'h00;
                    dn  = 1'b1;
                    il  = !legal;
                end
            end
            if (hold) begin
                es = 1'b0; ec = 1'b0; erx = 8'h00; dn = 1'b0; il = 1'b0; rd = 1'b0;
            end
            chk("ctrl16", {mux_sel, en_s, en_c, en_rx, alu_sel, done, illegal, instr_ready},
                {m, es, ec, erx, as, dn, il, rd});
            chk("ctrl8", {mux_sel8, en_s8, en_c8, en_rx8, alu_sel8, done8, illegal8, instr_ready8},
                {m, es, ec, erx, as, dn, il, rd});
            chk("im_d16", im_d, imm);
            chk("im_d8", im_d8, imm[7:0]);
            chk("cnt16", retired_cnt, cnt_model);
            chk("cnt8", retired_cnt8, cnt_model[7:0]);
            if (fl) begin
                if (hold) begin
                    holds++;
                end else if (done || p >= 3) begin
                    void'(q.pop_front());
                    holds     = 0;
                    last_imm  = imm;
                    cnt_model = cnt_model + 16'd1;
                end
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single R-type, then I-type and illegal back to back.
        send(16'h2404);
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(16'hE1E1);
        send(16'h0003);
        send(16'h2404);
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Two-cycle stall in EXEC.
        send(16'h4A09);
        instr_valid = 1'b0;
        @(negedge clk);
        force_hold = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // Reset asserted in EXEC aborts the instruction.
        send(16'h6C10);
        instr_valid = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ctrl", {mux_sel, en_s, en_c, en_rx, alu_sel, done, illegal, instr_ready},
            {4'd9, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1});
        chk("rst_cnt", retired_cnt, 16'h0000);
        chk("rst_imd", im_d, 16'h0000);
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Random traffic with random stalls; enough retirements to wrap the 8-bit counter.
        rand_hold = 1'b1;
        for (int i = 0; i < 320; i++) begin
            send(16'($urandom));
            if ($urandom_range(3) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(3)) @(posedge clk);
                #1;
            end
        end
        instr_valid = 1'b0;
        rand_hold   = 1'b0;
        for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk);
        chk("drain", q.size(), 0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bitty_ctrl_fsm.md
Name: bitty_ctrl_fsm

Overview:
Multi-cycle control sequencer for the 8-register, 16-bit datapath. It accepts one instruction per handshake and decodes its fields. It then steps the operand mux through three phases (load S, execute into C, write-back to Rx), producing the mux select, the register enables and the immediate. It sits between the instruction source and the datapath (register file, operand mux, ALU).

Parameters:
DATA_W, 16, datapath width; im_d and the retired counter are this wide.
IMM_W, 8, immediate field width; zero-extended to DATA_W.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
instr  in  16  instruction word, sampled on accept.
instr_valid  in  1  source has an instruction.
instr_ready  out  1  controller can accept; high only in IDLE with hold low.
hold  in  1  stall; freezes the FSM and forces all enables low.
mux_sel  out  4  operand mux select: 0-7 = Rx/Ry, 8 = im_d, 9 = def_val.
im_d  out  DATA_W  zero-extended immediate of the current instruction.
en_s  out  1  load S register from the mux output.
en_c  out  1  load C register from the ALU.
en_rx  out  8  one-hot write enable for register file write-back from C.
alu_sel  out  3  ALU operation code.
done  out  1  one-cycle pulse; instruction retired.
illegal  out  1  one-cycle pulse with done when fmt is illegal.
retired_cnt  out  DATA_W  count of retired instructions.

Behaviour:
- Instruction fields: [15:13] Rx, [12:10] Ry, [12:5] imm8 (I-type), [4:2] alu_op, [1:0] fmt. fmt 00 = R-type, 01 = I-type, 10/11 = illegal.
- Accept: on a clk edge with instr_valid && instr_ready. instr is latched into an internal register; FSM moves IDLE -> LOAD_S.
- States and outputs. All outputs are decoded from the state and the latched instruction only.
  - IDLE: mux_sel=9, all enables 0.
  - LOAD_S: mux_sel=Rx, en_s=1.
  - EXEC: mux_sel=Ry for R-type or 8 for I-type; en_c=1; alu_sel=alu_op.
  - WRITE: mux_sel=9; en_rx bit Rx=1 (all zero if illegal); done=1; illegal=1 if fmt illegal.
  - WRITE -> IDLE unconditionally.
- Latency: accept at edge N; done is high in cycle N+3; instr_ready is high again in cycle N+4. Throughput is one instruction per 4 cycles.
- Illegal fmt: the full LOAD_S/EXEC/WRITE sequence still runs, so timing is constant, but en_s, en_c and en_rx stay 0.
- im_d = {zeros, imm8} of the latched instruction. It is held stable from LOAD_S through WRITE and keeps its last value in IDLE.
- hold high: state, latched instruction and counter are frozen; all enables, done and illegal are forced 0; instr_ready=0. When hold is released, the same state's outputs reassert. A done that was suppressed by hold reappears exactly once.
- retired_cnt increments by 1 in each WRITE cycle not under hold, illegal instructions included. It wraps from 0xFFFF to 0x0000.
- instr_valid deasserting while in a non-IDLE state has no effect. No input is sampled outside the accept edge.
- Reset (async assert, sync-safe deassert):
  - Values: state=IDLE, latched instr=0, im_d=0, retired_cnt=0, mux_sel=9, enables/done/illegal=0, instr_ready=1 (when hold is low).
  - Reset mid-operation aborts the instruction with no write-back and no done.

Decomposition:
- Shared package bitty_pkg holds:
  - the state enum (IDLE, LOAD_S, EXEC, WRITE);
  - the fmt codes FMT_R=2'b00 and FMT_I=2'b01;
  - mux select constants SEL_IMM=4'b1000 and SEL_DEF=4'b1001;
  - field-position constants.
- One natural sub-module, bitty_instr_decode: combinational decode of the latched word into Rx, Ry, imm, alu_op and the is_imm/is_illegal flags.

Test Plan:
- R-type instr=0x2404 (Rx=1, Ry=1, alu_op=1, fmt=00), accepted at cycle 0:
  - cycle 1: mux_sel=1, en_s=1;
  - cycle 2: mux_sel=1, en_c=1, alu_sel=1;
  - cycle 3: en_rx=0x02, done=1, mux_sel=9;
  - cycle 4: instr_ready=1; retired_cnt=1.
- I-type instr=0xE1E1 (Rx=7, imm8=0x0F, alu_op=0, fmt=01) -> im_d=0x000F; EXEC mux_sel=8; WRITE en_rx=0x80.
- Illegal instr=0x0003 -> no en_s/en_c/en_rx; done=1 and illegal=1 in cycle 3; retired_cnt still increments.
- hold asserted during EXEC for 2 cycles -> en_c=0 during hold, then one EXEC cycle with en_c=1; done is delayed by 2 cycles; instr_ready=0 throughout.
- Back-to-back: instr_valid held high with two instructions -> second accepted 4 cycles after the first; never during LOAD_S/EXEC/WRITE.
- reset_n pulsed low in EXEC -> outputs return to reset values immediately, with no done and no en_rx; retired_cnt=0. Preload the counter to 0xFFFF, retire one instruction -> counter reads 0x0000.
